pwm_fault_gate: RTL

- Protection stage directly downstream of the PWM chain; consumes the chain's per-channel out_a/out_b pairs.
- Filters and latches external fault inputs (trip-zone) and forces the outputs to a configured safe state on a fault.
- Drives stop_request back into the chain and waits for a qualified clear before re-enabling the outputs.

---
 rtl/pwm_fault_gate_pkg.sv | 20 ++
 rtl/pwm_fault_gate_if.sv | 32 +++
 rtl/pwm_fault_gate_fault_line_filter.sv | 54 +++++
 rtl/pwm_fault_gate.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pwm_fault_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fault_pkg
// Description : Shared types and constants for the PWM fault gate.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_fault_pkg;

  // Depth of the fault-line metastability synchronizer.
  localparam int SYNC_DEPTH = 2;

  // Protection state machine encoding.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    TRIPPED  = 2'd1,
    CLEARING = 2'd2
  } gate_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_fault_gate_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fault_gate_if
// Description : PWM chain link: complementary pairs and counter status in,
//               stop request back out to the chain.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_fault_gate_if #(
  parameter int N_CHANNELS = 3
);
  logic [N_CHANNELS-1:0] pwm_in_a;
  logic [N_CHANNELS-1:0] pwm_in_b;
  logic                  counter_status;
  logic                  stop_request;

  // PWM chain side.
  modport master (
    output pwm_in_a,
    output pwm_in_b,
    output counter_status,
    input  stop_request
  );

  // Fault gate side.
  modport slave (
    input  pwm_in_a,
    input  pwm_in_b,
    input  counter_status,
    output stop_request
  );
endinterface
`default_nettype wire

// File: rtl/pwm_fault_gate_fault_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : fault_line_filter
// Description : One trip-zone line: synchronizer, polarity correction and
//               saturating glitch filter producing a registered qualified flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fault_line_filter
  import pwm_fault_pkg::*;
#(
  parameter int FILTER_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fault_in,
  input  logic                    fault_polarity,
  input  logic [FILTER_WIDTH-1:0] filter_length,
  output logic                    qualified
);

  logic [SYNC_DEPTH-1:0]   r_sync;
  logic [FILTER_WIDTH-1:0] r_count;
  logic                    w_sample;
  logic [FILTER_WIDTH:0]   w_count_next;
  logic [FILTER_WIDTH:0]   w_threshold;

  // Active-high sample after synchronization; a zero length behaves as one.
  assign w_sample     = r_sync[SYNC_DEPTH-1] ^ fault_polarity;
  assign w_count_next = {1'b0, r_count} + {{FILTER_WIDTH{1'b0}}, 1'b1};
  assign w_threshold  = (filter_length == '0) ? {{FILTER_WIDTH{1'b0}}, 1'b1}
                                              : {1'b0, filter_length};

  // Bring the asynchronous line into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_DEPTH-2:0], fault_in};
  end

  // Count consecutive active samples; qualify once the run reaches the length.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      qualified <= 1'b0;
    end else if (w_sample) begin
      if (r_count != {FILTER_WIDTH{1'b1}}) r_count <= w_count_next[FILTER_WIDTH-1:0];
      qualified <= (w_count_next >= w_threshold);
    end else begin
      r_count   <= '0;
      qualified <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_fault_gate.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fault_gate
// Description : Trip-zone protection stage. Filters fault lines, forces the
//               PWM pairs to a safe state, stops the chain and waits for a
//               qualified clear before releasing the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fault_gate
  import pwm_fault_pkg::*;
#(
  parameter int N_CHANNELS   = 3,
  parameter int N_FAULTS     = 4,
  parameter int FILTER_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  pwm_fault_gate_if.slave         chain,
  input  logic [N_FAULTS-1:0]     fault_in,
  input  logic [N_FAULTS-1:0]     fault_enable,
  input  logic [N_FAULTS-1:0]     fault_polarity,
  input  logic [FILTER_WIDTH-1:0] filter_length,
  input  logic [N_CHANNELS-1:0]   safe_state_a,
  input  logic [N_CHANNELS-1:0]   safe_state_b,
  input  logic                    fault_clear,
  output logic [N_CHANNELS-1:0]   out_a,
  output logic [N_CHANNELS-1:0]   out_b,
  output logic                    fault_active,
  output logic [N_FAULTS-1:0]     first_fault,
  output logic [N_FAULTS-1:0]     fault_flags
);

  gate_state_t           r_state;
  gate_state_t           w_state_next;
  logic [N_FAULTS-1:0]   w_qualified;
  logic [N_FAULTS-1:0]   w_trip_vec;
  logic                  w_trip;
  logic [N_CHANNELS-1:0] w_safe_a;
  logic [N_CHANNELS-1:0] w_safe_b;
  logic [N_CHANNELS-1:0] w_out_a_d;
  logic [N_CHANNELS-1:0] w_out_b_d;
  logic                  w_stop_d;
  logic                  w_active_d;
  logic [N_FAULTS-1:0]   w_first_d;
  logic [N_FAULTS-1:0]   w_flags_d;
  logic                  r_stop;

  generate
    for (genvar gi = 0; gi < N_FAULTS; gi++) begin : g_line
      fault_line_filter #(
        .FILTER_WIDTH (FILTER_WIDTH)
      ) u_filter (
        .clock          (clock),
        .reset          (reset),
        .fault_in       (fault_in[gi]),
        .fault_polarity (fault_polarity[gi]),
        .filter_length  (filter_length),
        .qualified      (w_qualified[gi])
      );
    end
  endgenerate

  // Only enabled lines trip; disabled lines keep filtering in the background.
  assign w_trip_vec = w_qualified & fault_enable;
  assign w_trip     = |w_trip_vec;

  // Shoot-through guard: a pair requested as 11 is driven 00 instead.
  assign w_safe_a = safe_state_a & ~safe_state_b;
  assign w_safe_b = safe_state_b & ~safe_state_a;

  assign chain.stop_request = r_stop;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a trip always beats a clear or a restart.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:      if (w_trip) w_state_next = TRIPPED;
      TRIPPED:  if (!w_trip && fault_clear && !chain.counter_status)
                  w_state_next = CLEARING;
      CLEARING: if (w_trip) w_state_next = TRIPPED;
                else if (chain.counter_status) w_state_next = RUN;
      default:  w_state_next = RUN;
    endcase
  end

  // Output decode from the next state so outputs move with the state register.
  always_comb begin
    w_out_a_d  = w_safe_a;
    w_out_b_d  = w_safe_b;
    w_stop_d   = (w_state_next == TRIPPED);
    w_active_d = (w_state_next != RUN);
    w_first_d  = first_fault;
    w_flags_d  = fault_flags | w_trip_vec;
    if (w_state_next == RUN) begin
      w_out_a_d = chain.pwm_in_a;
      w_out_b_d = chain.pwm_in_b;
      w_first_d = '0;
      w_flags_d = '0;
    end else if (r_state == RUN) begin
      w_first_d = w_trip_vec;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_a        <= '0;
      out_b        <= '0;
      r_stop       <= 1'b0;
      fault_active <= 1'b0;
      first_fault  <= '0;
      fault_flags  <= '0;
    end else begin
      out_a        <= w_out_a_d;
      out_b        <= w_out_b_d;
      r_stop       <= w_stop_d;
      fault_active <= w_active_d;
      first_fault  <= w_first_d;
      fault_flags  <= w_flags_d;
    end
  end

endmodule
`default_nettype wire
